// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmit types, frame constants and baud helper
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - one-byte 8N1 serialiser with its own baud counter
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] byte_i,
    input  logic                 start_i,
    output logic                 tx_o,
    output logic                 byte_done_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [CW-1:0]          baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   tx_q, tx_d;
    logic                   bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    // start_i is honoured in the last stop cycle too, so bytes chain with no idle gap
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        tx_d        = tx_q;
        byte_done_o = 1'b0;
        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = '0;
                    shreg_d = byte_i;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        state_d = STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        byte_done_o = 1'b1;
                        if (start_i) begin
                            state_d = START;
                            bit_d   = '0;
                            shreg_d = byte_i;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/count_uart_tx.sv
// rtl/count_uart_tx.sv - multi-byte word to back-to-back 8N1 frames, LSB byte first
module count_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
    parameter int NBYTES       = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [8*NBYTES-1:0]   data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

    logic          active_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  word_q, word_nxt;
    logic [7:0]    byte_in;
    logic          byte_done, byte_start, last_byte;
    logic          word_done, next_byte, accept;

    assign word_nxt  = word_q >> 8;
    assign last_byte = (idx_q == IDX_LAST);
    assign word_done = active_q && byte_done && last_byte;
    assign next_byte = active_q && byte_done && !last_byte;

    // Ready during the final stop cycle lets the next word start on the completion edge
    assign ready_o    = !active_q || word_done;
    assign busy_o     = ~ready_o;
    assign done_o     = word_done;
    assign accept     = valid_i && ready_o && !rst_i;
    assign byte_start = accept || next_byte;
    assign byte_in    = accept ? data_i[7:0] : word_nxt[7:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            idx_q    <= '0;
            word_q   <= '0;
        end else if (accept) begin
            active_q <= 1'b1;
            idx_q    <= '0;
            word_q   <= data_i;
        end else if (next_byte) begin
            idx_q    <= idx_q + 1'b1;
            word_q   <= word_nxt;
        end else if (word_done) begin
            active_q <= 1'b0;
            idx_q    <= '0;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .byte_i      (byte_in),
        .start_i     (byte_start),
        .tx_o        (tx_o),
        .byte_done_o (byte_done)
    );

endmodule

// File: tb/tb_count_uart_tx.sv
// tb/tb_count_uart_tx.sv - directed self-checking bench for count_uart_tx
module tb_count_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic        valid, ready, tx, busy, done;
    logic [7:0]  data1;
    logic        valid1, ready1, tx1, busy1, done1;

    int checks = 0;
    int failures = 0;

    logic cap_tx   [0:899];
    logic cap_rdy  [0:899];
    logic cap_done [0:899];

    always #5 clk = ~clk;

    count_uart_tx #(.CLK_HZ(1000), .BAUD(100), .NBYTES(4)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
        .ready_o(ready), .tx_o(tx), .busy_o(busy), .done_o(done)
    );

    count_uart_tx #(.CLK_HZ(1000), .BAUD(100), .NBYTES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .data_i(data1), .valid_i(valid1),
        .ready_o(ready1), .tx_o(tx1), .busy_o(busy1), .done_o(done1)
    );

    // Expected line level i cycles after the first start-bit cycle (10 clocks per bit)
    function automatic logic exp_line(input logic [31:0] w, input int nb, input int i);
        int b, p;
        if (i < 0) return 1'b1;
        b = i / 100;
        p = (i % 100) / 10;
        if (b >= nb) return 1'b1;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return w[b*8 + p - 1];
    endfunction

    function automatic logic [7:0] dec_byte(input int base);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = cap_tx[base + k*10 + 15];
        return b;
    endfunction

    task automatic launch(input logic [31:0] w, input logic keep_valid);
        @(negedge clk);
        data = w;
        valid = 1'b1;
        @(negedge clk);
        if (!keep_valid) valid = 1'b0;
    endtask

    task automatic capture(input int n, input int ev_idx, input logic ev_valid,
                           input logic [31:0] ev_data, input logic ev_pulse);
        for (int i = 0; i < n; i++) begin
            cap_tx[i] = tx;
            cap_rdy[i] = ready;
            cap_done[i] = done;
            if (i == ev_idx) begin
                valid = ev_valid;
                data = ev_data;
            end
            if (ev_pulse && i == ev_idx + 1) valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; valid = 1'b0; data = '0; valid1 = 1'b0; data1 = '0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if ({tx1, ready1, busy1, done1} !== 4'b1100) begin
            failures++; $display("FAIL reset_n1 got=%b exp=1100", {tx1, ready1, busy1, done1});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word;
        int mism, first_bad, rdy_bad, dn_cnt, dn_at;
        logic [7:0] expb [4];
        expb = '{8'h78, 8'h56, 8'h34, 8'h12};
        launch(32'h1234_5678, 1'b0);
        capture(420, -1, 1'b0, 32'h0, 1'b0);
        checks++; if (cap_tx[0] !== 1'b0) begin failures++; $display("FAIL single_first_fall got=%b exp=0", cap_tx[0]); end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (dec_byte(b*100) !== expb[b] || cap_tx[b*100+5] !== 1'b0 || cap_tx[b*100+95] !== 1'b1) begin
                failures++;
                $display("FAIL single_byte%0d got=%h start=%b stop=%b exp=%h start=0 stop=1",
                         b, dec_byte(b*100), cap_tx[b*100+5], cap_tx[b*100+95], expb[b]);
            end
        end
        mism = 0; first_bad = -1; rdy_bad = 0; dn_cnt = 0; dn_at = -1;
        for (int i = 0; i < 420; i++) begin
            if (cap_tx[i] !== exp_line(32'h1234_5678, 4, i)) begin
                mism++; if (first_bad < 0) first_bad = i;
            end
            if (i < 399 && cap_rdy[i] !== 1'b0) rdy_bad++;
            if (i >= 399 && cap_rdy[i] !== 1'b1) rdy_bad++;
            if (cap_done[i] === 1'b1) begin dn_cnt++; dn_at = i; end
        end
        checks++; if (mism != 0) begin failures++; $display("FAIL single_line mismatches=%0d first_at=%0d exp=0", mism, first_bad); end
        checks++; if (rdy_bad != 0) begin failures++; $display("FAIL single_ready bad_cycles=%0d exp=0", rdy_bad); end
        checks++; if (dn_cnt != 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", dn_cnt); end
        // done is the last stop-bit cycle: fall cycle 0 through done cycle spans 400 clocks
        checks++; if (dn_at + 1 != 400) begin failures++; $display("FAIL single_done_time got=%0d exp=400", dn_at + 1); end
    endtask

    task automatic test_bit_timing;
        int bad_edges, mism;
        logic [7:0] bits;
        launch(32'h0000_00AA, 1'b0);
        capture(420, -1, 1'b0, 32'h0, 1'b0);
        bad_edges = 0; mism = 0;
        for (int i = 1; i < 420; i++) begin
            if (cap_tx[i] !== cap_tx[i-1] && (i % 10) != 0) bad_edges++;
            if (cap_tx[i] !== exp_line(32'h0000_00AA, 4, i)) mism++;
        end
        for (int k = 0; k < 8; k++) bits[k] = cap_tx[k*10 + 15];
        checks++; if (bits !== 8'hAA) begin failures++; $display("FAIL timing_bits got=%b exp=10101010", bits); end
        checks++; if (bad_edges != 0) begin failures++; $display("FAIL timing_edges off_grid=%0d exp=0", bad_edges); end
        checks++; if (mism != 0) begin failures++; $display("FAIL timing_line mismatches=%0d exp=0", mism); end
        checks++; if (cap_tx[100] !== 1'b0 || cap_tx[99] !== 1'b1) begin
            failures++; $display("FAIL timing_gap got=%b%b exp=10", cap_tx[99], cap_tx[100]);
        end
    endtask

    task automatic test_back_to_back;
        int mism, dn_cnt, first_bad;
        logic e;
        launch(32'hFFFF_FFFF, 1'b1);
        data = 32'h0000_0000;
        capture(820, 400, 1'b0, 32'h0, 1'b0);
        mism = 0; dn_cnt = 0; first_bad = -1;
        for (int i = 0; i < 820; i++) begin
            e = (i < 400) ? exp_line(32'hFFFF_FFFF, 4, i) : exp_line(32'h0, 4, i - 400);
            if (cap_tx[i] !== e) begin mism++; if (first_bad < 0) first_bad = i; end
            if (cap_done[i] === 1'b1) dn_cnt++;
        end
        checks++; if (mism != 0) begin failures++; $display("FAIL b2b_line mismatches=%0d first_at=%0d exp=0", mism, first_bad); end
        checks++; if (dn_cnt != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", dn_cnt); end
        checks++; if (cap_done[399] !== 1'b1 || cap_done[799] !== 1'b1) begin
            failures++; $display("FAIL b2b_done_pos got=%b%b exp=11", cap_done[399], cap_done[799]);
        end
        checks++; if (cap_rdy[400] !== 1'b0 || cap_rdy[810] !== 1'b1) begin
            failures++; $display("FAIL b2b_ready got=%b%b exp=01", cap_rdy[400], cap_rdy[810]);
        end
    endtask

    task automatic test_busy_ignore;
        int mism, dn_cnt, idle_bad;
        launch(32'hA5C3_0F81, 1'b0);
        capture(500, 150, 1'b1, 32'hDEAD_BEEF, 1'b1);
        mism = 0; dn_cnt = 0; idle_bad = 0;
        for (int i = 0; i < 500; i++) begin
            if (cap_tx[i] !== exp_line(32'hA5C3_0F81, 4, i)) mism++;
            if (cap_done[i] === 1'b1) dn_cnt++;
            if (i >= 400 && cap_rdy[i] !== 1'b1) idle_bad++;
        end
        checks++; if (mism != 0) begin failures++; $display("FAIL busy_line mismatches=%0d exp=0", mism); end
        checks++; if (dn_cnt != 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", dn_cnt); end
        checks++; if (idle_bad != 0) begin failures++; $display("FAIL busy_idle_ready bad_cycles=%0d exp=0", idle_bad); end
    endtask

    task automatic test_reset_mid_frame;
        int idle_bad, mism;
        logic [7:0] expb [4];
        expb = '{8'hE1, 8'h96, 8'h5A, 8'h3C};
        launch(32'hC0FF_EE11, 1'b0);
        repeat (145) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL midrst_tx got=%b exp=1", tx); end
        checks++; if (ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL midrst_ready got=%b busy=%b exp=1 busy=0", ready, busy);
        end
        idle_bad = 0;
        for (int i = 0; i < 150; i++) begin
            if (tx !== 1'b1 || done !== 1'b0 || ready !== 1'b1) idle_bad++;
            @(negedge clk);
        end
        checks++; if (idle_bad != 0) begin failures++; $display("FAIL midrst_idle bad_cycles=%0d exp=0", idle_bad); end
        launch(32'h3C5A_96E1, 1'b0);
        capture(420, -1, 1'b0, 32'h0, 1'b0);
        mism = 0;
        for (int i = 0; i < 420; i++) if (cap_tx[i] !== exp_line(32'h3C5A_96E1, 4, i)) mism++;
        for (int b = 0; b < 4; b++) if (dec_byte(b*100) !== expb[b]) mism++;
        checks++; if (mism != 0) begin failures++; $display("FAIL midrst_fresh mismatches=%0d exp=0", mism); end
        checks++; if (cap_done[399] !== 1'b1) begin failures++; $display("FAIL midrst_fresh_done got=%b exp=1", cap_done[399]); end
    endtask

    task automatic test_reset_wins;
        int bad;
        @(negedge clk);
        rst = 1'b1; valid = 1'b1; data = 32'h5555_5555;
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx !== 1'b1 || ready !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rst_wins bad_cycles=%0d exp=0", bad); end
    endtask

    task automatic test_nbytes1;
        int low_cnt, last_low, dn_cnt, dn_at;
        @(negedge clk);
        data1 = 8'h00; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        low_cnt = 0; last_low = -1; dn_cnt = 0; dn_at = -1;
        for (int i = 0; i < 120; i++) begin
            if (tx1 === 1'b0) begin low_cnt++; last_low = i; end
            if (done1 === 1'b1) begin dn_cnt++; dn_at = i; end
            @(negedge clk);
        end
        checks++; if (low_cnt != 90) begin failures++; $display("FAIL n1_low_cycles got=%0d exp=90", low_cnt); end
        checks++; if (last_low != 89) begin failures++; $display("FAIL n1_last_low got=%0d exp=89", last_low); end
        checks++; if (dn_cnt != 1 || dn_at != 99) begin
            failures++; $display("FAIL n1_done got_count=%0d at=%0d exp_count=1 at=99", dn_cnt, dn_at);
        end
        checks++; if (ready1 !== 1'b1 || tx1 !== 1'b1) begin
            failures++; $display("FAIL n1_idle got_ready=%b tx=%b exp=1 1", ready1, tx1);
        end
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_bit_timing;
        test_back_to_back;
        test_busy_ignore;
        test_reset_mid_frame;
        test_reset_wins;
        test_nbytes1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1);
    end

endmodule
